dcache_port_arbiter: RTL and testbench
======================================

# dcache_port_arbiter

Arbitrates the single data-cache request port between speculative loads leaving the load/store unit's second stage and committed stores retired by the ROB. Committed stores are queued in a small write-back buffer so that retirement never stalls on the cache port. Loads get priority by default; stores win when the buffer is full, when a store has waited too long, or during a fence drain. The block sits between the load/store unit, the ROB store-commit path and the non-blocking data cache. It replaces the "stall load on `cache_writeback_valid`" hazard with an explicit grant.

## Interface
- `DATA_WIDTH`, 32, data bits
- `ADDR_BITS`, 32, address bits
- `R_WIDTH`, 6, destination register bits
- `MICROOP`, 5, micro-operation bits
- `ROB_TICKET`, 3, ROB ticket bits
- `WB_DEPTH`, 4, write-back buffer entries; power of two, ≥2
- `STARVE_LIMIT`, 3, consecutive load wins tolerated while a store waits; 0 means stores always win

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `flush_valid` in 1: pipeline flush; blocks load grant this cycle
- `st_commit_valid` in 1: ROB presents a committed store
- `st_commit_addr` in ADDR_BITS, `st_commit_data` in DATA_WIDTH, `st_commit_microop` in MICROOP: store payload
- `st_commit_ready` out 1: buffer accepts a store; equals ~full
- `ld_req_valid` in 1: LSU presents a load
- `ld_req_addr` in ADDR_BITS, `ld_req_dest` in R_WIDTH, `ld_req_microop` in MICROOP, `ld_req_ticket` in ROB_TICKET: load payload
- `ld_req_ready` out 1: load granted this cycle; LSU pops its stage
- `cache_blocked` in 1: cache cannot accept a request this cycle
- `cache_req_valid` out 1: request issued to the cache
- `cache_req_is_store` out 1: 1 = store from buffer head, 0 = load
- `cache_req_addr` out ADDR_BITS, `cache_req_data` out DATA_WIDTH, `cache_req_microop` out MICROOP, `cache_req_dest` out R_WIDTH, `cache_req_ticket` out ROB_TICKET: muxed payload; data/dest/ticket are 0 when unused
- `fence_req` in 1: single-cycle pulse requesting a drain of all buffered stores
- `fence_done` out 1: single-cycle pulse; buffer drained
- `wb_count` out $clog2(WB_DEPTH)+1: occupancy

## Operation
- Push: `st_commit_valid & st_commit_ready` writes the tail entry. `st_commit_valid` while full is a protocol violation; the entry is dropped and the bench asserts on it.
- Candidates: store = buffer non-empty; load = `ld_req_valid & ~flush_valid & state==NORMAL`.
- `store_pri` = (state==DRAIN) | full | (starve_cnt ≥ STARVE_LIMIT).
- `grant_st` = ~cache_blocked & ~empty & (store_pri | ~load cand).
- `grant_ld` = ~cache_blocked & load cand & ~grant_st.
- `cache_req_valid` = grant_st | grant_ld. `ld_req_ready` = grant_ld. A store grant pops the head.
- `starve_cnt` (saturating):
  - cleared on grant_st or when the buffer is empty;
  - incremented on grant_ld while non-empty;
  - held otherwise, including blocked cycles.
- FSM NORMAL/DRAIN:
  - NORMAL + fence_req with (count after this cycle) > 0 → DRAIN.
  - NORMAL + fence_req with buffer empty after this cycle → stay NORMAL; fence_done next cycle.
  - DRAIN: loads not granted. When count after this cycle reaches 0 → NORMAL, and fence_done pulses in the first NORMAL cycle.
  - fence_req in DRAIN is ignored. Stores committed during DRAIN are drained too.
- Flush never discards buffered stores; they are architecturally committed.

## Timing
- Grant is combinational on the request cycle, with zero added latency. A store pushed at cycle t is issuable at t+1 at the earliest.
- Simultaneous push and pop: count unchanged. Push on a full buffer is impossible because ready is low, even if a pop occurs in the same cycle.
- Pointer wrap-around is modulo WB_DEPTH; full and empty are distinguished by the extra count bit.
- Reset (async, any time) loads these values: empty buffer, pointers 0, count 0, starve_cnt 0, state NORMAL, fence_done 0. Buffered stores are lost.
- Output values during reset follow from those registers: cache_req_valid 0, ld_req_ready 0, st_commit_ready 1, wb_count 0.

## Structure
- Shared package:
  - `wb_entry_t` {addr, microop, data};
  - `arb_state_e` {ARB_NORMAL, ARB_DRAIN}.
- One sub-module, `wb_fifo`: a parameterised circular buffer of `wb_entry_t` with push/pop/full/empty/count.
- The arbiter, starvation counter and FSM live in the top module.

## Test plan
- Idle buffer, load 0x100 with cache free → same-cycle grant: cache_req_valid=1, is_store=0, addr=0x100, ld_req_ready=1.
- One store committed at t, load held valid every cycle, STARVE_LIMIT=3 → loads granted at t+1..t+3; store granted at t+4; starve_cnt back to 0.
- Commit 4 stores back-to-back with cache_blocked=1 → st_commit_ready=0 after the 4th, wb_count=4. Release cache_blocked → store issued despite a pending load, ready=1 next cycle.
- 2 stores buffered, fence_req pulse, load pending → 2 store grants, no load grant, fence_done pulses one cycle after the last pop, then the load is granted.
- flush_valid with load valid and empty buffer → no cache request. Flush with a store buffered → the store is still issued.
- rst_n dropped mid-drain with 3 entries → outputs immediately at reset values; after release, wb_count=0, state NORMAL, no stale store issued.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: write-back buffer entry and arbiter FSM state.
package dcache_port_arbiter_pkg;

    // Default payload widths; the top builds its own entry type from its parameters.
    localparam int unsigned WB_ADDR_BITS  = 32;
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_MICROOP    = 5;

    typedef struct packed {
        logic [WB_ADDR_BITS-1:0]  addr;
        logic [WB_MICROOP-1:0]    microop;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_DRAIN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dcache_port_arbiter_wb_fifo.sv
// Circular write-back buffer of committed stores. Head entry is visible combinationally;
// full and empty come from an occupancy counter one bit wider than the pointers.
module wb_fifo
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and counter registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    // NOTE: storage has no reset; an entry is only ever read after being written, and the
    // reset counter already marks every slot invalid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single data-cache request port between LSU loads and buffered committed
// stores. Loads win by default; stores win when the buffer is full, when a store has been
// passed over STARVE_LIMIT times, or while a fence drain is in progress.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_BITS    = 32,
    parameter int unsigned R_WIDTH      = 6,
    parameter int unsigned MICROOP      = 5,
    parameter int unsigned ROB_TICKET   = 3,
    parameter int unsigned WB_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_valid,
    input  logic                      st_commit_valid,
    input  logic [ADDR_BITS-1:0]      st_commit_addr,
    input  logic [DATA_WIDTH-1:0]     st_commit_data,
    input  logic [MICROOP-1:0]        st_commit_microop,
    output logic                      st_commit_ready,
    input  logic                      ld_req_valid,
    input  logic [ADDR_BITS-1:0]      ld_req_addr,
    input  logic [R_WIDTH-1:0]        ld_req_dest,
    input  logic [MICROOP-1:0]        ld_req_microop,
    input  logic [ROB_TICKET-1:0]     ld_req_ticket,
    output logic                      ld_req_ready,
    input  logic                      cache_blocked,
    output logic                      cache_req_valid,
    output logic                      cache_req_is_store,
    output logic [ADDR_BITS-1:0]      cache_req_addr,
    output logic [DATA_WIDTH-1:0]     cache_req_data,
    output logic [MICROOP-1:0]        cache_req_microop,
    output logic [R_WIDTH-1:0]        cache_req_dest,
    output logic [ROB_TICKET-1:0]     cache_req_ticket,
    input  logic                      fence_req,
    output logic                      fence_done,
    output logic [$clog2(WB_DEPTH):0] wb_count
);

    localparam int unsigned CNT_W    = $clog2(WB_DEPTH) + 1;
    localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    // Entry layout mirrors wb_entry_t but follows this instance's widths.
    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [MICROOP-1:0]    microop;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t              push_entry, head;
    logic                full, empty;
    logic                push, ld_cand, store_pri, grant_st, grant_ld;
    logic [CNT_W-1:0]    count_after;
    logic [STARVE_W-1:0] starve_q, starve_d;
    arb_state_e          state_q;
    logic                fence_done_q;

    assign push_entry      = '{addr: st_commit_addr, microop: st_commit_microop, data: st_commit_data};
    assign st_commit_ready = ~full;
    assign ld_req_ready    = grant_ld;
    assign cache_req_valid = grant_st | grant_ld;
    assign fence_done      = fence_done_q;

    wb_fifo #(
        .DEPTH   (WB_DEPTH),
        .entry_t (entry_t)
    ) u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (grant_st),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (wb_count)
    );

    // Candidate selection, priority and grants; everything here resolves in the request cycle.
    // NOTE: combinational logic uses blocking assignments and gives every output a value up
    // front so that no path through the block leaves a latch behind.
    always_comb begin
        push        = st_commit_valid & ~full;
        ld_cand     = ld_req_valid & ~flush_valid & (state_q == ARB_NORMAL);
        store_pri   = (state_q == ARB_DRAIN) | full | (starve_q >= STARVE_W'(STARVE_LIMIT));
        grant_st    = ~cache_blocked & ~empty & (store_pri | ~ld_cand);
        grant_ld    = ~cache_blocked & ld_cand & ~grant_st;
        count_after = wb_count + CNT_W'(push) - CNT_W'(grant_st);
    end

    // Request payload mux; fields the winner does not use are driven to zero.
    always_comb begin
        cache_req_is_store = 1'b0;
        cache_req_addr     = '0;
        cache_req_data     = '0;
        cache_req_microop  = '0;
        cache_req_dest     = '0;
        cache_req_ticket   = '0;
        if (grant_st) begin
            cache_req_is_store = 1'b1;
            cache_req_addr     = head.addr;
            cache_req_data     = head.data;
            cache_req_microop  = head.microop;
        end else if (grant_ld) begin
            cache_req_addr     = ld_req_addr;
            cache_req_microop  = ld_req_microop;
            cache_req_dest     = ld_req_dest;
            cache_req_ticket   = ld_req_ticket;
        end
    end

    // Starvation counter next state: counts load wins over a waiting store, saturating.
    always_comb begin
        starve_d = starve_q;
        if (grant_st || empty) begin
            starve_d = '0;
        end else if (grant_ld && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starvation counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Fence FSM: enters DRAIN while stores remain, pulses fence_done once the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_NORMAL;
            fence_done_q <= 1'b0;
        end else begin
            fence_done_q <= 1'b0;
            unique case (state_q)
                ARB_NORMAL: begin
                    if (fence_req) begin
                        if (count_after != '0) begin
                            state_q <= ARB_DRAIN;
                        end else begin
                            fence_done_q <= 1'b1;
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (count_after == '0) begin
                        state_q      <= ARB_NORMAL;
                        fence_done_q <= 1'b1;
                    end
                end
                default: state_q <= ARB_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are compared 2 units later.
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_valid;
    logic        st_commit_valid;
    logic [31:0] st_commit_addr;
    logic [31:0] st_commit_data;
    logic [4:0]  st_commit_microop;
    logic        st_commit_ready;
    logic        ld_req_valid;
    logic [31:0] ld_req_addr;
    logic [5:0]  ld_req_dest;
    logic [4:0]  ld_req_microop;
    logic [2:0]  ld_req_ticket;
    logic        ld_req_ready;
    logic        cache_blocked;
    logic        cache_req_valid;
    logic        cache_req_is_store;
    logic [31:0] cache_req_addr;
    logic [31:0] cache_req_data;
    logic [4:0]  cache_req_microop;
    logic [5:0]  cache_req_dest;
    logic [2:0]  cache_req_ticket;
    logic        fence_req;
    logic        fence_done;
    logic [2:0]  wb_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_BITS    (32),
        .R_WIDTH      (6),
        .MICROOP      (5),
        .ROB_TICKET   (3),
        .WB_DEPTH     (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_valid        (flush_valid),
        .st_commit_valid    (st_commit_valid),
        .st_commit_addr     (st_commit_addr),
        .st_commit_data     (st_commit_data),
        .st_commit_microop  (st_commit_microop),
        .st_commit_ready    (st_commit_ready),
        .ld_req_valid       (ld_req_valid),
        .ld_req_addr        (ld_req_addr),
        .ld_req_dest        (ld_req_dest),
        .ld_req_microop     (ld_req_microop),
        .ld_req_ticket      (ld_req_ticket),
        .ld_req_ready       (ld_req_ready),
        .cache_blocked      (cache_blocked),
        .cache_req_valid    (cache_req_valid),
        .cache_req_is_store (cache_req_is_store),
        .cache_req_addr     (cache_req_addr),
        .cache_req_data     (cache_req_data),
        .cache_req_microop  (cache_req_microop),
        .cache_req_dest     (cache_req_dest),
        .cache_req_ticket   (cache_req_ticket),
        .fence_req          (fence_req),
        .fence_done         (fence_done),
        .wb_count           (wb_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        flush_valid       = 1'b0;
        st_commit_valid   = 1'b0;
        st_commit_addr    = '0;
        st_commit_data    = '0;
        st_commit_microop = '0;
        ld_req_valid      = 1'b0;
        ld_req_addr       = '0;
        ld_req_dest       = '0;
        ld_req_microop    = '0;
        ld_req_ticket     = '0;
        cache_blocked     = 1'b0;
        fence_req         = 1'b0;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] uop);
        st_commit_valid   = 1'b1;
        st_commit_addr    = addr;
        st_commit_data    = data;
        st_commit_microop = uop;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [5:0] dest,
                              input logic [4:0] uop, input logic [2:0] ticket);
        ld_req_valid   = 1'b1;
        ld_req_addr    = addr;
        ld_req_dest    = dest;
        ld_req_microop = uop;
        ld_req_ticket  = ticket;
    endtask

    // A committed store must never be offered while the buffer refuses it.
    always @(negedge clk) begin
        if (rst_n && st_commit_valid) begin
            check("commit_offered_while_full", st_commit_ready, 1);
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        settle();
        check("rst_req_valid", cache_req_valid, 0);
        check("rst_ld_ready", ld_req_ready, 0);
        check("rst_st_ready", st_commit_ready, 1);
        check("rst_wb_count", wb_count, 0);
        check("rst_fence_done", fence_done, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Idle buffer: load granted in the same cycle.
        drive_load(32'h100, 6'd5, 5'd3, 3'd2);
        settle();
        check("ld_valid", cache_req_valid, 1);
        check("ld_is_store", cache_req_is_store, 0);
        check("ld_addr", cache_req_addr, 32'h100);
        check("ld_ready", ld_req_ready, 1);
        check("ld_dest", cache_req_dest, 5);
        check("ld_ticket", cache_req_ticket, 2);
        check("ld_uop", cache_req_microop, 3);
        check("ld_data_zero", cache_req_data, 0);
        next_cycle();

        // Starvation: store pushed at t, loads win t+1..t+3, store wins at t+4.
        drive_load(32'h110, 6'd1, 5'd1, 3'd1);
        drive_store(32'h200, 32'hCAFE_0001, 5'd7);
        settle();
        check("starve_t_ld_ready", ld_req_ready, 1);
        check("starve_t_is_store", cache_req_is_store, 0);
        next_cycle();
        st_commit_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            settle();
            check($sformatf("starve_ld_ready_t%0d", i), ld_req_ready, 1);
            check($sformatf("starve_is_store_t%0d", i), cache_req_is_store, 0);
            check($sformatf("starve_count_t%0d", i), wb_count, 1);
            next_cycle();
        end
        settle();
        check("starve_st_valid", cache_req_valid, 1);
        check("starve_st_is_store", cache_req_is_store, 1);
        check("starve_st_addr", cache_req_addr, 32'h200);
        check("starve_st_data", cache_req_data, 32'hCAFE_0001);
        check("starve_st_uop", cache_req_microop, 7);
        check("starve_st_dest_zero", cache_req_dest, 0);
        check("starve_st_ticket_zero", cache_req_ticket, 0);
        check("starve_st_ld_ready", ld_req_ready, 0);
        next_cycle();
        settle();
        check("starve_after_ld_ready", ld_req_ready, 1);
        check("starve_after_count", wb_count, 0);
        next_cycle();

        // Fill the buffer while blocked; pointers wrap because rd/wr start at 1 here.
        idle_inputs();
        cache_blocked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 5'(i));
            settle();
            check($sformatf("fill_ready_%0d", i), st_commit_ready, 1);
            check($sformatf("fill_req_valid_%0d", i), cache_req_valid, 0);
            next_cycle();
        end
        st_commit_valid = 1'b0;
        settle();
        check("full_ready", st_commit_ready, 0);
        check("full_count", wb_count, 4);
        next_cycle();
        cache_blocked = 1'b0;
        drive_load(32'h104, 6'd9, 5'd2, 3'd4);
        settle();
        check("full_st_is_store", cache_req_is_store, 1);
        check("full_st_addr", cache_req_addr, 32'h300);
        check("full_st_data", cache_req_data, 32'h1000);
        check("full_ld_ready", ld_req_ready, 0);
        next_cycle();
        ld_req_valid = 1'b0;
        settle();
        check("after_full_ready", st_commit_ready, 1);
        check("after_full_count", wb_count, 3);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("order_is_store_%0d", i), cache_req_is_store, 1);
            check($sformatf("order_addr_%0d", i), cache_req_addr, 32'h300 + 32'(4 * i));
            check($sformatf("order_data_%0d", i), cache_req_data, 32'h1000 + 32'(i));
            next_cycle();
            settle();
        end
        check("drained_count", wb_count, 0);
        check("drained_req_valid", cache_req_valid, 0);
        next_cycle();

        // Fence with two stores buffered and a load pending.
        cache_blocked = 1'b1;
        drive_store(32'h400, 32'hA0, 5'd1);
        next_cycle();
        drive_store(32'h404, 32'hA1, 5'd2);
        next_cycle();
        st_commit_valid = 1'b0;
        drive_load(32'h120, 6'd3, 5'd4, 3'd5);
        fence_req = 1'b1;
        settle();
        check("fence_cyc_req_valid", cache_req_valid, 0);
        check("fence_cyc_count", wb_count, 2);
        next_cycle();
        fence_req     = 1'b0;
        cache_blocked = 1'b0;
        settle();
        check("drain1_is_store", cache_req_is_store, 1);
        check("drain1_addr", cache_req_addr, 32'h400);
        check("drain1_ld_ready", ld_req_ready, 0);
        check("drain1_fence_done", fence_done, 0);
        next_cycle();
        settle();
        check("drain2_is_store", cache_req_is_store, 1);
        check("drain2_addr", cache_req_addr, 32'h404);
        check("drain2_ld_ready", ld_req_ready, 0);
        check("drain2_fence_done", fence_done, 0);
        next_cycle();
        settle();
        check("fence_done_pulse", fence_done, 1);
        check("post_fence_ld_ready", ld_req_ready, 1);
        check("post_fence_addr", cache_req_addr, 32'h120);
        next_cycle();
        ld_req_valid = 1'b0;
        settle();
        check("fence_done_single", fence_done, 0);
        next_cycle();

        // Fence with an empty buffer: done on the next cycle.
        fence_req = 1'b1;
        settle();
        check("empty_fence_now", fence_done, 0);
        next_cycle();
        fence_req = 1'b0;
        settle();
        check("empty_fence_done", fence_done, 1);
        next_cycle();
        settle();
        check("empty_fence_single", fence_done, 0);
        next_cycle();

        // Flush blocks loads but never buffered stores.
        flush_valid = 1'b1;
        drive_load(32'h130, 6'd2, 5'd1, 3'd3);
        settle();
        check("flush_req_valid", cache_req_valid, 0);
        check("flush_ld_ready", ld_req_ready, 0);
        next_cycle();
        flush_valid   = 1'b0;
        ld_req_valid  = 1'b0;
        cache_blocked = 1'b1;
        drive_store(32'h500, 32'h55, 5'd6);
        next_cycle();
        st_commit_valid = 1'b0;
        cache_blocked   = 1'b0;
        flush_valid     = 1'b1;
        drive_load(32'h134, 6'd2, 5'd1, 3'd3);
        settle();
        check("flush_st_valid", cache_req_valid, 1);
        check("flush_st_is_store", cache_req_is_store, 1);
        check("flush_st_addr", cache_req_addr, 32'h500);
        check("flush_st_ld_ready", ld_req_ready, 0);
        next_cycle();
        idle_inputs();
        settle();
        check("flush_after_count", wb_count, 0);
        next_cycle();

        // Asynchronous reset in the middle of a drain with three stores buffered.
        cache_blocked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h600 + 32'(4 * i), 32'h60 + 32'(i), 5'd0);
            next_cycle();
        end
        st_commit_valid = 1'b0;
        fence_req       = 1'b1;
        next_cycle();
        fence_req = 1'b0;
        settle();
        check("pre_rst_state", dut.state_q, ARB_DRAIN);
        check("pre_rst_count", wb_count, 3);
        cache_blocked = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("mid_rst_req_valid", cache_req_valid, 0);
        check("mid_rst_ld_ready", ld_req_ready, 0);
        check("mid_rst_st_ready", st_commit_ready, 1);
        check("mid_rst_count", wb_count, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        settle();
        check("post_rst_count", wb_count, 0);
        check("post_rst_state", dut.state_q, ARB_NORMAL);
        check("post_rst_req_valid", cache_req_valid, 0);
        check("post_rst_fence_done", fence_done, 0);
        next_cycle();
        settle();
        check("post_rst_no_stale", cache_req_valid, 0);
        check("post_rst_fence_done2", fence_done, 0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
